// File: rtl/ibex_lsu_data_ctrl_pkg.sv
// Shared types and byte-lane helpers for the LSU data-side controller.
package ibex_lsu_data_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID,
    WAIT_GNT_2,
    WAIT_RVALID_2
  } ls_fsm_e;

  typedef enum logic [1:0] {
    LSU_WORD = 2'b00,
    LSU_HALF = 2'b01,
    LSU_BYTE = 2'b10
  } lsu_type_e;

  // An access needs a second bus beat when it crosses a word boundary.
  function automatic logic is_misaligned(logic [1:0] lsu_type, logic [1:0] offset);
    case (lsu_type)
      LSU_HALF: return offset == 2'b11;
      LSU_BYTE: return 1'b0;
      default:  return offset != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] be_first(logic [1:0] lsu_type, logic [1:0] offset);
    case (lsu_type)
      LSU_HALF: return (offset == 2'b11) ? 4'b1000 : (4'b0011 << offset);
      LSU_BYTE: return 4'b0001 << offset;
      default:  return 4'b1111 << offset;
    endcase
  endfunction

  // Only reached for misaligned accesses; bytes are never split.
  function automatic logic [3:0] be_second(logic [1:0] lsu_type, logic [1:0] offset);
    case (lsu_type)
      LSU_HALF: return 4'b0001;
      LSU_BYTE: return 4'b0000;
      default:  return 4'b1111 >> (3'd4 - {1'b0, offset});
    endcase
  endfunction

  // Rotate store data so each byte lands on its lane for both beats.
  function automatic logic [31:0] rotl_bytes(logic [31:0] data, logic [1:0] offset);
    case (offset)
      2'd1:    return {data[23:0], data[31:24]};
      2'd2:    return {data[15:0], data[31:16]};
      2'd3:    return {data[7:0],  data[31:8]};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/ibex_lsu_data_ctrl_if.sv
// Data-side bus between the LSU (master) and memory/interconnect (slave).
interface ibex_lsu_data_ctrl_if;
  logic        data_req;
  logic        data_gnt;
  logic        data_rvalid;
  logic        data_err;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_addr, data_we, data_be, data_wdata,
    input  data_gnt, data_rvalid, data_err, data_rdata
  );

  modport slave (
    input  data_req, data_addr, data_we, data_be, data_wdata,
    output data_gnt, data_rvalid, data_err, data_rdata
  );
endinterface

// File: rtl/ibex_lsu_data_ctrl_rdata_align.sv
// Load data alignment: shift the two-beat window, truncate to size, extend.
module ibex_lsu_rdata_align
  import ibex_lsu_data_ctrl_pkg::*;
(
  input  logic [31:0] rdata_first,
  input  logic [31:0] rdata_second,
  input  logic [1:0]  offset,
  input  logic [1:0]  lsu_type,
  input  logic        sign_ext,
  output logic [31:0] rdata_out
);

  logic [31:0] shifted;

  // Select the addressed bytes, then extend according to access size.
  always_comb begin
    shifted = 32'({rdata_second, rdata_first} >> {offset, 3'b000});
    case (lsu_type)
      LSU_HALF: rdata_out = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      LSU_BYTE: rdata_out = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      default:  rdata_out = shifted;
    endcase
  end

endmodule

// File: rtl/ibex_lsu_data_ctrl.sv
// LSU data-side controller: splits misaligned accesses into two aligned
// beats and returns aligned, extended load data to writeback.
module ibex_lsu_data_ctrl
  import ibex_lsu_data_ctrl_pkg::*;
#(
  parameter bit ResetAll = 1'b0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        lsu_req_i,
  input  logic                        lsu_we_i,
  input  logic [1:0]                  lsu_type_i,
  input  logic                        lsu_sign_ext_i,
  input  logic [31:0]                 lsu_addr_i,
  input  logic [31:0]                 lsu_wdata_i,
  output logic                        lsu_req_done_o,
  output logic                        lsu_busy_o,
  ibex_lsu_data_ctrl_if.master        bus,
  output logic [31:0]                 lsu_rdata_o,
  output logic                        lsu_rdata_valid_o,
  output logic                        lsu_resp_valid_o,
  output logic                        lsu_resp_err_o
);

  ls_fsm_e     state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  type_q;
  logic        we_q, sign_ext_q, err_q;

  logic        idle, capture, beat1_store, second_beat, req;
  logic [31:0] cur_addr, cur_wdata, base_addr, aligned_rdata, align_first;
  logic [1:0]  cur_type, offset;
  logic        cur_we, misaligned;

  // In IDLE the bus is driven straight from ID/EX; afterwards from the capture registers.
  always_comb begin
    idle        = (state_q == IDLE);
    cur_addr    = idle ? lsu_addr_i  : addr_q;
    cur_wdata   = idle ? lsu_wdata_i : wdata_q;
    cur_type    = idle ? lsu_type_i  : type_q;
    cur_we      = idle ? lsu_we_i    : we_q;
    offset      = cur_addr[1:0];
    misaligned  = is_misaligned(cur_type, offset);
    base_addr   = {cur_addr[31:2], 2'b00};
    second_beat = (state_q == WAIT_RVALID) || (state_q == WAIT_GNT_2);
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d          = state_q;
    req              = 1'b0;
    lsu_req_done_o   = 1'b0;
    lsu_resp_valid_o = 1'b0;
    lsu_resp_err_o   = 1'b0;
    capture          = 1'b0;
    beat1_store      = 1'b0;
    case (state_q)
      IDLE: begin
        req = lsu_req_i;
        if (lsu_req_i) begin
          capture = 1'b1;
          if (bus.data_gnt) begin
            state_d        = WAIT_RVALID;
            lsu_req_done_o = ~misaligned;
          end else begin
            state_d = WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        req = 1'b1;
        if (bus.data_gnt) begin
          state_d        = WAIT_RVALID;
          lsu_req_done_o = ~misaligned;
        end
      end
      WAIT_RVALID: begin
        if (bus.data_rvalid) begin
          beat1_store = 1'b1;
          if (misaligned) begin
            // Second beat goes out in the same cycle the first response lands.
            req = 1'b1;
            if (bus.data_gnt) begin
              state_d        = WAIT_RVALID_2;
              lsu_req_done_o = 1'b1;
            end else begin
              state_d = WAIT_GNT_2;
            end
          end else begin
            lsu_resp_valid_o = 1'b1;
            lsu_resp_err_o   = bus.data_err;
            state_d          = IDLE;
          end
        end
      end
      WAIT_GNT_2: begin
        req = 1'b1;
        if (bus.data_gnt) begin
          state_d        = WAIT_RVALID_2;
          lsu_req_done_o = 1'b1;
        end
      end
      WAIT_RVALID_2: begin
        if (bus.data_rvalid) begin
          lsu_resp_valid_o = 1'b1;
          lsu_resp_err_o   = bus.data_err | err_q;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus fields are forced to zero whenever no request is presented.
  always_comb begin
    bus.data_req   = req;
    bus.data_we    = req & cur_we;
    bus.data_addr  = req ? (second_beat ? base_addr + 32'd4 : base_addr) : '0;
    bus.data_be    = req ? (second_beat ? be_second(cur_type, offset)
                                        : be_first(cur_type, offset)) : '0;
    bus.data_wdata = req ? rotl_bytes(cur_wdata, offset) : '0;
  end

  // Control state: FSM, captured access attributes and beat-1 error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      type_q     <= '0;
      we_q       <= 1'b0;
      sign_ext_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        type_q     <= lsu_type_i;
        we_q       <= lsu_we_i;
        sign_ext_q <= lsu_sign_ext_i;
      end
      if (beat1_store) err_q <= bus.data_err;
    end
  end

  if (ResetAll) begin : g_dp_rst
    // Datapath capture registers with reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        addr_q  <= '0;
        wdata_q <= '0;
        rdata_q <= '0;
      end else begin
        if (capture) begin
          addr_q  <= lsu_addr_i;
          wdata_q <= lsu_wdata_i;
        end
        if (beat1_store) rdata_q <= bus.data_rdata;
      end
    end
  end else begin : g_dp_norst
    // Datapath capture registers without reset.
    always_ff @(posedge clk_i) begin
      if (capture) begin
        addr_q  <= lsu_addr_i;
        wdata_q <= lsu_wdata_i;
      end
      if (beat1_store) rdata_q <= bus.data_rdata;
    end
  end

  // Aligned accesses complete on beat 1, so the live bus data is the low word.
  assign align_first = (state_q == WAIT_RVALID_2) ? rdata_q : bus.data_rdata;

  ibex_lsu_rdata_align u_rdata_align (
    .rdata_first  (align_first),
    .rdata_second (bus.data_rdata),
    .offset       (addr_q[1:0]),
    .lsu_type     (type_q),
    .sign_ext     (sign_ext_q),
    .rdata_out    (aligned_rdata)
  );

  assign lsu_rdata_o       = lsu_resp_valid_o ? aligned_rdata : '0;
  assign lsu_rdata_valid_o = lsu_resp_valid_o & ~we_q & ~lsu_resp_err_o;
  assign lsu_busy_o        = ~idle;

  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.data_req && !bus.data_gnt |=> $stable(bus.data_addr) && $stable(bus.data_be)
                                      && $stable(bus.data_wdata));
  a_rdata_valid_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lsu_rdata_valid_o |-> lsu_resp_valid_o);
  a_rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.data_rvalid |-> (state_q == WAIT_RVALID) || (state_q == WAIT_RVALID_2));

endmodule

// File: tb/tb_ibex_lsu_data_ctrl.sv
// Scoreboard bench for the LSU data-side controller.
module tb_ibex_lsu_data_ctrl;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        err;
  } resp_t;

  beat_t beat_q[$];
  resp_t resp_q[$];
  beat_t eb;
  resp_t er;
  int total = 0;
  int bad   = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_req = 1'b0, lsu_we = 1'b0, lsu_sign_ext = 1'b0;
  logic [1:0]  lsu_type = 2'b00;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0;
  logic        req_done, busy, rdata_valid, resp_valid, resp_err;
  logic [31:0] lsu_rdata;

  always #5 clk = ~clk;

  ibex_lsu_data_ctrl_if bus ();

  ibex_lsu_data_ctrl #(.ResetAll(1'b0)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .lsu_req_i         (lsu_req),
    .lsu_we_i          (lsu_we),
    .lsu_type_i        (lsu_type),
    .lsu_sign_ext_i    (lsu_sign_ext),
    .lsu_addr_i        (lsu_addr),
    .lsu_wdata_i       (lsu_wdata),
    .lsu_req_done_o    (req_done),
    .lsu_busy_o        (busy),
    .bus               (bus.master),
    .lsu_rdata_o       (lsu_rdata),
    .lsu_rdata_valid_o (rdata_valid),
    .lsu_resp_valid_o  (resp_valid),
    .lsu_resp_err_o    (resp_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},         32'(bus.data_req), 32'd0);
    check({tag, "_addr"},        bus.data_addr, 32'd0);
    check({tag, "_be"},          32'(bus.data_be), 32'd0);
    check({tag, "_wdata"},       bus.data_wdata, 32'd0);
    check({tag, "_we"},          32'(bus.data_we), 32'd0);
    check({tag, "_busy"},        32'(busy), 32'd0);
    check({tag, "_req_done"},    32'(req_done), 32'd0);
    check({tag, "_resp_valid"},  32'(resp_valid), 32'd0);
    check({tag, "_resp_err"},    32'(resp_err), 32'd0);
    check({tag, "_rdata_valid"}, 32'(rdata_valid), 32'd0);
    check({tag, "_rdata"},       lsu_rdata, 32'd0);
  endtask

  function automatic beat_t mk_beat(logic [31:0] a, logic w, logic [3:0] b, logic [31:0] d, logic l);
    beat_t t;
    t.addr = a; t.we = w; t.be = b; t.wdata = d; t.last = l;
    return t;
  endfunction

  function automatic resp_t mk_resp(logic [31:0] d, logic v, logic e);
    resp_t t;
    t.rdata = d; t.rdata_valid = v; t.err = e;
    return t;
  endfunction

  // Drives one access from ID/EX and plays the memory side: each beat is
  // granted after d stall cycles, and answered the cycle after its grant.
  task automatic access(input logic we, input logic [1:0] typ, input logic sext,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int unsigned nb, input int unsigned d,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic e1, input logic e2);
    lsu_req = 1'b1; lsu_we = we; lsu_type = typ; lsu_sign_ext = sext;
    lsu_addr = addr; lsu_wdata = wdata;
    for (int unsigned b = 0; b < nb; b++) begin
      for (int unsigned c = 0; c <= d; c++) begin
        bus.data_gnt = (c == d);
        if (b == 1 && c == 0) begin
          bus.data_rvalid = 1'b1; bus.data_rdata = r1; bus.data_err = e1;
        end else begin
          bus.data_rvalid = 1'b0; bus.data_rdata = '0; bus.data_err = 1'b0;
        end
        tick();
        if (c == d && b == nb - 1) lsu_req = 1'b0;
      end
    end
    bus.data_gnt    = 1'b0;
    bus.data_rvalid = 1'b1;
    bus.data_rdata  = (nb == 2) ? r2 : r1;
    bus.data_err    = (nb == 2) ? e2 : e1;
    tick();
    bus.data_rvalid = 1'b0; bus.data_rdata = '0; bus.data_err = 1'b0;
    tick();
  endtask

  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic [3:0]  prev_be;

  // Monitor: compares granted beats and responses against the queues.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_req",   32'(bus.data_req), 32'd1);
        check("hold_addr",  bus.data_addr, prev_addr);
        check("hold_be",    32'(bus.data_be), 32'(prev_be));
        check("hold_wdata", bus.data_wdata, prev_wdata);
      end
      prev_hold  = bus.data_req && !bus.data_gnt;
      prev_addr  = bus.data_addr;
      prev_be    = bus.data_be;
      prev_wdata = bus.data_wdata;

      if (bus.data_req && bus.data_gnt) begin
        if (beat_q.size() == 0) begin
          check("beat_expected", 32'(beat_q.size()), 32'd1);
        end else begin
          eb = beat_q.pop_front();
          check("beat_addr",     bus.data_addr, eb.addr);
          check("beat_we",       32'(bus.data_we), 32'(eb.we));
          check("beat_be",       32'(bus.data_be), 32'(eb.be));
          check("beat_wdata",    bus.data_wdata, eb.wdata);
          check("beat_req_done", 32'(req_done), 32'(eb.last));
        end
      end else begin
        check("stray_req_done", 32'(req_done), 32'd0);
      end

      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          check("resp_expected", 32'(resp_q.size()), 32'd1);
        end else begin
          er = resp_q.pop_front();
          check("resp_rdata_valid", 32'(rdata_valid), 32'(er.rdata_valid));
          check("resp_err",         32'(resp_err), 32'(er.err));
          if (er.rdata_valid) check("resp_rdata", lsu_rdata, er.rdata);
        end
      end else begin
        check("rdata_valid_alone", 32'(rdata_valid), 32'd0);
      end
    end
  end

  initial begin
    bus.data_gnt = 1'b0; bus.data_rvalid = 1'b0; bus.data_err = 1'b0; bus.data_rdata = '0;
    tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Aligned word load.
    beat_q.push_back(mk_beat(32'h0000_0100, 1'b0, 4'b1111, 32'h0, 1'b1));
    resp_q.push_back(mk_resp(32'hDEAD_BEEF, 1'b1, 1'b0));
    access(1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0, 1, 0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);

    // Half loads at offset 2, signed then unsigned.
    beat_q.push_back(mk_beat(32'h0000_0100, 1'b0, 4'b1100, 32'h0, 1'b1));
    resp_q.push_back(mk_resp(32'hFFFF_8001, 1'b1, 1'b0));
    access(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 1, 0, 32'h8001_0000, 32'h0, 1'b0, 1'b0);
    beat_q.push_back(mk_beat(32'h0000_0100, 1'b0, 4'b1100, 32'h0, 1'b1));
    resp_q.push_back(mk_resp(32'h0000_8001, 1'b1, 1'b0));
    access(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 1, 0, 32'h8001_0000, 32'h0, 1'b0, 1'b0);

    // Signed byte load at offset 1.
    beat_q.push_back(mk_beat(32'h0000_0400, 1'b0, 4'b0010, 32'h0, 1'b1));
    resp_q.push_back(mk_resp(32'hFFFF_FF9A, 1'b1, 1'b0));
    access(1'b0, 2'b10, 1'b1, 32'h0000_0401, 32'h0, 1, 1, 32'h1234_9A78, 32'h0, 1'b0, 1'b0);

    // Misaligned word load at offset 3.
    beat_q.push_back(mk_beat(32'h0000_0200, 1'b0, 4'b1000, 32'h0, 1'b0));
    beat_q.push_back(mk_beat(32'h0000_0204, 1'b0, 4'b0111, 32'h0, 1'b1));
    resp_q.push_back(mk_resp(32'h6677_8811, 1'b1, 1'b0));
    access(1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0, 2, 0, 32'h1122_3344, 32'h5566_7788, 1'b0, 1'b0);

    // Misaligned word store wrapping the address space, grants stalled.
    beat_q.push_back(mk_beat(32'hFFFF_FFFC, 1'b1, 4'b1100, 32'hCCDD_AABB, 1'b0));
    beat_q.push_back(mk_beat(32'h0000_0000, 1'b1, 4'b0011, 32'hCCDD_AABB, 1'b1));
    resp_q.push_back(mk_resp(32'h0, 1'b0, 1'b0));
    access(1'b1, 2'b00, 1'b0, 32'hFFFF_FFFE, 32'hAABB_CCDD, 2, 2, 32'h0, 32'h0, 1'b0, 1'b0);

    // Byte store at offset 3.
    beat_q.push_back(mk_beat(32'h0000_0600, 1'b1, 4'b1000, 32'hEE00_0000, 1'b1));
    resp_q.push_back(mk_resp(32'h0, 1'b0, 1'b0));
    access(1'b1, 2'b10, 1'b0, 32'h0000_0603, 32'h0000_00EE, 1, 0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Misaligned half load, beat 1 errors: beat 2 still issued, no writeback.
    beat_q.push_back(mk_beat(32'h0000_0300, 1'b0, 4'b1000, 32'h0, 1'b0));
    beat_q.push_back(mk_beat(32'h0000_0304, 1'b0, 4'b0001, 32'h0, 1'b1));
    resp_q.push_back(mk_resp(32'h0, 1'b0, 1'b1));
    access(1'b0, 2'b01, 1'b0, 32'h0000_0303, 32'h0, 2, 1, 32'hAA00_0000, 32'h0000_00BB, 1'b1, 1'b0);

    // Reset while waiting for the second response.
    beat_q.push_back(mk_beat(32'h0000_0500, 1'b0, 4'b1110, 32'h0, 1'b0));
    beat_q.push_back(mk_beat(32'h0000_0504, 1'b0, 4'b0001, 32'h0, 1'b1));
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_type = 2'b00; lsu_sign_ext = 1'b0;
    lsu_addr = 32'h0000_0501; lsu_wdata = '0;
    bus.data_gnt = 1'b1;
    tick();
    bus.data_rvalid = 1'b1; bus.data_rdata = 32'h0102_0304;
    tick();
    lsu_req = 1'b0; bus.data_gnt = 1'b0; bus.data_rvalid = 1'b0; bus.data_rdata = '0;
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    tick();
    bus.data_rvalid = 1'b1; bus.data_rdata = 32'h5A5A_5A5A;
    #2;
    check("stray_rvalid_resp", 32'(resp_valid), 32'd0);
    check("stray_rvalid_rdv",  32'(rdata_valid), 32'd0);
    tick();
    bus.data_rvalid = 1'b0; bus.data_rdata = '0;
    rst_n = 1'b1;
    tick();

    // Recovery after reset: unsigned byte load at offset 2.
    beat_q.push_back(mk_beat(32'h0000_0700, 1'b0, 4'b0100, 32'h0, 1'b1));
    resp_q.push_back(mk_resp(32'h0000_0080, 1'b1, 1'b0));
    access(1'b0, 2'b10, 1'b0, 32'h0000_0702, 32'h0, 1, 0, 32'h0080_0000, 32'h0, 1'b0, 1'b0);

    tick();
    check("beats_left", 32'(beat_q.size()), 32'd0);
    check("resps_left", 32'(resp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
